shift_seq_ctrl: RTL and testbench
=================================

SHIFT_SEQ_CTRL -- requirements
Module: shift_seq_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, data register width in bits.
REQ-002 The block SHALL have parameter CNT_W, default 3, shift-count field width in bits; maximum count is 2^CNT_W-1.
REQ-003 The block SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-low reset; reset=0 forces reset state immediately, independent of clk.
REQ-005 The block SHALL have port start  input  1  request to run one load-and-shift job; accepted only when ready=1.
REQ-006 The block SHALL have port load_data  input  WIDTH  initial register contents for the job.
REQ-007 The block SHALL have port shift_dir  input  1  0=shift left (toward MSB), 1=shift right (toward LSB).
REQ-008 The block SHALL have port shift_count  input  CNT_W  number of single-bit shifts to perform, 0 allowed.
REQ-009 The block SHALL have port rotate  input  1  1=bit shifted out re-enters at the opposite end, 0=zero fill.
REQ-010 The block SHALL have port abort  input  1  terminates an active job early.
REQ-011 The block SHALL have port ready  output  1  high only in IDLE; job may be accepted.
REQ-012 The block SHALL have port data_out  output  WIDTH  current register contents.
REQ-013 The block SHALL have port serial_out  output  1  bit ejected by the most recent shift.
REQ-014 The block SHALL have port done  output  1  one-cycle pulse marking job completion.
REQ-015 The block SHALL have port aborted  output  1  valid with done; 1 if the job ended via abort.

Function
REQ-016 The block SHALL implement FSM states IDLE, SHIFT, DONE; reset state IDLE.
REQ-017 In IDLE, start=1 at a rising edge SHALL latch load_data into data_out, latch shift_dir, rotate, shift_count into internal registers, clear serial_out, then go to SHIFT if shift_count!=0, else DONE.
REQ-018 Inputs load_data, shift_dir, rotate, shift_count SHALL be sampled only at acceptance; later changes SHALL not affect the running job.
REQ-019 start SHALL be ignored while ready=0; no queuing.
REQ-020 In SHIFT, each rising edge SHALL perform exactly one shift and decrement the remaining count; the edge performing the last shift SHALL move to DONE.
REQ-021 Left shift: data_out <= {data_out[WIDTH-2:0], fill}, serial_out <= old MSB; right shift: data_out <= {fill, data_out[WIDTH-1:1]}, serial_out <= old LSB; fill = ejected bit if rotate=1, else 0.
REQ-022 Shift counts larger than WIDTH SHALL be performed literally (e.g. 7 shifts of 4 bits), no saturation or modulo.
REQ-023 abort=1 in SHIFT SHALL take priority over shifting: no shift on that edge, state goes to DONE, aborted flag set; abort in IDLE or DONE SHALL be ignored.
REQ-024 DONE SHALL last exactly one cycle with done=1, ready=0, data_out holding the final value, then return to IDLE.
REQ-025 Latency: for count N>0 without abort, done SHALL be high in the cycle after the Nth shift edge, i.e. N+1 cycles after the acceptance edge; for N=0, in the cycle after acceptance.
REQ-026 data_out and serial_out SHALL hold their values in IDLE until the next accepted job.
REQ-027 aborted SHALL be 0 for a normally completed job and remain valid until the next acceptance.

Reset
REQ-028 While reset=0: state IDLE, data_out=0, serial_out=0, done=0, aborted=0, remaining count=0, ready=1.
REQ-029 Reset asserted mid-job SHALL discard the job immediately with no done pulse; after release the block SHALL accept start on the first rising edge.

Verification
REQ-030 Reset: reset=0 with clk toggling -> data_out=0000, serial_out=0, done=0, ready=1.
REQ-031 start, load_data=1110, dir=0, count=2, rotate=0 -> data_out 1110, 1100, 1000 on successive edges; serial_out 1 then 1; done=1 with 1000, aborted=0.
REQ-032 start, load_data=0110, dir=1, count=3, rotate=1 -> 0011, 1001, 1100; serial_out 0,1,1; done with 1100.
REQ-033 start, load_data=1010, count=0 -> done next cycle, data_out=1010, serial_out=0, no shift.
REQ-034 start count=5 on 0001 left, zero fill; start re-pulsed during SHIFT ignored; abort after 2 shifts -> data_out=0100, done=1, aborted=1.
REQ-035 Reset driven low asynchronously between edges during SHIFT -> data_out=0000, ready=1 immediately, no done pulse; new job after release runs correctly.

Source files
------------

// File: rtl/shift_seq_ctrl_if.sv
// shift_seq_ctrl_if: job request and result signals of the shift sequencer
interface shift_seq_ctrl_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
);
    logic             start;
    logic [WIDTH-1:0] load_data;
    logic             shift_dir;
    logic [CNT_W-1:0] shift_count;
    logic             rotate;
    logic             abort;
    logic             ready;
    logic [WIDTH-1:0] data_out;
    logic             serial_out;
    logic             done;
    logic             aborted;
    modport master (
        output start, load_data, shift_dir, shift_count, rotate, abort,
        input  ready, data_out, serial_out, done, aborted
    );
    modport slave (
        input  start, load_data, shift_dir, shift_count, rotate, abort,
        output ready, data_out, serial_out, done, aborted
    );
endinterface

// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: load-and-shift job sequencer with rotate/zero-fill, abort and done pulse
module shift_seq_ctrl #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input logic           clk,
    input logic           reset,
    shift_seq_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d, shifted;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ser_q, ser_d, dir_q, dir_d, rot_q, rot_d, abt_q, abt_d;
    logic             ejected, fill;
    always_comb begin
        ejected = dir_q ? data_q[0] : data_q[WIDTH-1];
        fill    = rot_q & ejected;
        shifted = dir_q ? {fill, data_q[WIDTH-1:1]} : {data_q[WIDTH-2:0], fill};
        state_d = state_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        ser_d   = ser_q;
        dir_d   = dir_q;
        rot_d   = rot_q;
        abt_d   = abt_q;
        case (state_q)
            IDLE: if (bus.start) begin
                data_d  = bus.load_data;
                dir_d   = bus.shift_dir;
                rot_d   = bus.rotate;
                cnt_d   = bus.shift_count;
                ser_d   = 1'b0;
                abt_d   = 1'b0;
                state_d = (bus.shift_count != '0) ? SHIFT : DONE;
            end
            SHIFT: if (bus.abort) begin
                abt_d   = 1'b1;
                state_d = DONE;
            end else begin
                data_d  = shifted;
                ser_d   = ejected;
                cnt_d   = cnt_q - CNT_W'(1);
                state_d = (cnt_q == CNT_W'(1)) ? DONE : SHIFT;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            data_q  <= '0;
            cnt_q   <= '0;
            ser_q   <= 1'b0;
            dir_q   <= 1'b0;
            rot_q   <= 1'b0;
            abt_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            ser_q   <= ser_d;
            dir_q   <= dir_d;
            rot_q   <= rot_d;
            abt_q   <= abt_d;
        end
    end
    assign bus.ready      = (state_q == IDLE);
    assign bus.done       = (state_q == DONE);
    assign bus.data_out   = data_q;
    assign bus.serial_out = ser_q;
    assign bus.aborted    = abt_q;
endmodule

// File: tb/tb_shift_seq_ctrl.sv
// tb_shift_seq_ctrl: directed and random jobs checked against a bit-level shift model
module tb_shift_seq_ctrl;
    localparam int W = 4;
    localparam int C = 3;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;
    always #5 clk = ~clk;
    shift_seq_ctrl_if #(.WIDTH(W), .CNT_W(C)) bus ();
    shift_seq_ctrl #(.WIDTH(W), .CNT_W(C)) dut (.clk(clk), .reset(reset), .bus(bus));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic scramble();
        bus.load_data   = W'($urandom);
        bus.shift_dir   = 1'($urandom);
        bus.shift_count = C'($urandom);
        bus.rotate      = 1'($urandom);
    endtask

    // ab = number of completed shifts after which abort is raised; negative means never
    task automatic run_job(input logic [W-1:0] ld, input logic dir, input int cnt,
                           input logic rot, input int ab, input bit noisy);
        int exp, ser, shifts, ej;
        bit abt;
        @(negedge clk);
        chk("ready_idle", 32'(bus.ready), 1);
        bus.start = 1'b1; bus.load_data = ld; bus.shift_dir = dir;
        bus.shift_count = C'(cnt); bus.rotate = rot; bus.abort = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        if (noisy) scramble();
        exp = int'(ld); ser = 0; shifts = 0; abt = 1'b0;
        chk("load_data", 32'(bus.data_out), 32'(exp));
        chk("load_ser", 32'(bus.serial_out), 0);
        while (shifts < cnt && !abt) begin
            chk("busy_ready", 32'(bus.ready), 0);
            chk("busy_done", 32'(bus.done), 0);
            if (ab == shifts) begin
                bus.abort = 1'b1;
                abt = 1'b1;
            end else begin
                if (dir) begin
                    ej  = exp % 2;
                    exp = exp / 2 + ((rot && ej == 1) ? (1 << (W - 1)) : 0);
                end else begin
                    ej  = exp / (1 << (W - 1));
                    exp = (exp * 2) % (1 << W) + ((rot && ej == 1) ? 1 : 0);
                end
                ser = ej;
                shifts++;
            end
            if (noisy) begin
                bus.start = 1'($urandom);
                scramble();
            end
            @(negedge clk);
            bus.abort = 1'b0;
            chk("shift_data", 32'(bus.data_out), 32'(exp));
            chk("shift_ser", 32'(bus.serial_out), 32'(ser));
        end
        chk("done_pulse", 32'(bus.done), 1);
        chk("done_ready", 32'(bus.ready), 0);
        chk("aborted", 32'(bus.aborted), 32'(abt));
        bus.start = 1'b0;
        bus.abort = 1'($urandom);
        @(negedge clk);
        bus.abort = 1'b0;
        chk("done_end", 32'(bus.done), 0);
        chk("idle_ready", 32'(bus.ready), 1);
        chk("hold_data", 32'(bus.data_out), 32'(exp));
        chk("hold_ser", 32'(bus.serial_out), 32'(ser));
        chk("hold_aborted", 32'(bus.aborted), 32'(abt));
    endtask

    initial begin
        bus.start = 1'b0; bus.load_data = '0; bus.shift_dir = 1'b0;
        bus.shift_count = '0; bus.rotate = 1'b0; bus.abort = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_data", 32'(bus.data_out), 0);
        chk("rst_ser", 32'(bus.serial_out), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_ready", 32'(bus.ready), 1);
        chk("rst_aborted", 32'(bus.aborted), 0);
        reset = 1'b1;
        run_job(4'b1110, 1'b0, 2, 1'b0, -1, 1'b0);
        run_job(4'b0110, 1'b1, 3, 1'b1, -1, 1'b0);
        run_job(4'b1010, 1'b0, 0, 1'b0, -1, 1'b0);
        run_job(4'b0001, 1'b0, 5, 1'b0, 2, 1'b1);
        run_job(4'b1001, 1'b1, 7, 1'b1, -1, 1'b1);
        // asynchronous reset in the middle of a shift job
        @(negedge clk);
        bus.start = 1'b1; bus.load_data = 4'b1011; bus.shift_dir = 1'b0;
        bus.shift_count = 3'd7; bus.rotate = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_data", 32'(bus.data_out), 0);
        chk("mid_rst_ready", 32'(bus.ready), 1);
        chk("mid_rst_ser", 32'(bus.serial_out), 0);
        chk("mid_rst_done", 32'(bus.done), 0);
        repeat (2) begin
            @(negedge clk);
            chk("rst_hold_done", 32'(bus.done), 0);
            chk("rst_hold_data", 32'(bus.data_out), 0);
        end
        reset = 1'b1;
        run_job(4'b0111, 1'b1, 2, 1'b0, -1, 1'b0);
        for (int i = 0; i < 40; i++) begin
            int c;
            c = int'($urandom_range(0, 7));
            run_job(W'($urandom), 1'($urandom), c, 1'($urandom),
                    ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : -1, 1'b1);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
